worldmap_port_arbiter: RTL

Shares one world_map read port among three requesters: the video scanner (vid), the rojobot worldmap lookup (bot) and a CPU/AHB debug read path (cpu). Video has priority. Bot and cpu share the remaining cycles round-robin, and a starvation guard can steal a video slot. Every grant is tagged through a fixed-latency return pipeline, so read data is steered back to the requester that issued the read. The block sits between the requesters and the world_map BRAM in the clk_out75 domain.

---
 rtl/wmarb_pkg.sv | 28 ++
 rtl/wmarb_tag_pipe.sv | 31 +++
 rtl/worldmap_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wmarb_pkg.sv
// Shared types and defaults for the world_map read-port arbiter.
// Holds the requester tag encoding, the return-pipeline entry and the stats helpers.
package wmarb_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VID  = 2'd1,
        REQ_BOT  = 2'd2,
        REQ_CPU  = 2'd3
    } req_id_e;

    localparam int WMARB_ADDR_W = 14;
    localparam int WMARB_DATA_W = 2;
    localparam int WMARB_STAT_W = 16;

    // One in-flight read: who issued it and whether it displaced a video slot.
    typedef struct packed {
        logic    valid;
        logic    stolen;
        req_id_e tag;
    } tag_t;

    function automatic logic [WMARB_STAT_W-1:0] sat_inc(input logic [WMARB_STAT_W-1:0] value,
                                                         input logic inc);
        return (inc && (value != '1)) ? value + 1'b1 : value;
    endfunction

endpackage

// File: rtl/wmarb_tag_pipe.sv
// Fixed-latency shift register carrying the requester tag of each granted read.
// The last stage lines up with the cycle in which that read's data is presented.
module wmarb_tag_pipe
    import wmarb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/worldmap_port_arbiter.sv
// Shares the world_map BRAM read port between video, rojobot and CPU debug reads.
// Optional grant/steal statistics are compiled in with the WMARB_STATS_EN macro.
module worldmap_port_arbiter
    import wmarb_pkg::*;
#(
    parameter int ADDR_W     = WMARB_ADDR_W,
    parameter int DATA_W     = WMARB_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int MAX_STARVE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_stale,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_gnt,
    output logic              bot_rvalid,
    output logic [DATA_W-1:0] bot_rdata,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
`ifdef WMARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [WMARB_STAT_W-1:0] stat_bot_cnt,
    output logic [WMARB_STAT_W-1:0] stat_cpu_cnt,
    output logic [WMARB_STAT_W-1:0] stat_steal_cnt
`endif
);

    localparam int STARVE_W = $clog2(MAX_STARVE + 1);

    logic [STARVE_W-1:0] r_starve;
    logic                r_rr_cpu;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_q;
    logic [DATA_W-1:0]   r_vid_hold;
    logic [DATA_W-1:0]   r_bot_hold;
    logic [DATA_W-1:0]   r_cpu_hold;

    logic                w_others;
    logic                w_pick_cpu;
    logic                w_steal;
    req_id_e             w_winner;
    logic [ADDR_W-1:0]   w_win_addr;
    tag_t                w_tag_in;
    tag_t                w_tag_out;
    logic                w_ret_valid;
    logic                w_ret_vid;
    logic                w_ret_bot;
    logic                w_ret_cpu;

    // Video normally wins; a due steal hands its slot to the round-robin pick.
    always_comb begin
        w_others   = bot_req | cpu_req;
        w_pick_cpu = cpu_req & (~bot_req | r_rr_cpu);
        w_steal    = ~reset & vid_req & w_others & (r_starve == STARVE_W'(MAX_STARVE));
        w_winner   = REQ_NONE;
        w_win_addr = r_mem_addr;
        if (reset) begin
            w_winner = REQ_NONE;
        end else if (vid_req && !w_steal) begin
            w_winner   = REQ_VID;
            w_win_addr = vid_addr;
        end else if (w_pick_cpu) begin
            w_winner   = REQ_CPU;
            w_win_addr = cpu_addr;
        end else if (bot_req) begin
            w_winner   = REQ_BOT;
            w_win_addr = bot_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve   <= '0;
            r_rr_cpu   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_addr <= w_win_addr;
            if (w_winner == REQ_BOT) begin
                r_rr_cpu <= 1'b1;
            end else if (w_winner == REQ_CPU) begin
                r_rr_cpu <= 1'b0;
            end
            if (!w_others || w_steal) begin
                r_starve <= '0;
            end else if (w_winner == REQ_VID) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    always_comb begin
        w_tag_in.valid  = (w_winner != REQ_NONE);
        w_tag_in.stolen = w_steal;
        w_tag_in.tag    = w_winner;
    end

    wmarb_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_ret_valid = w_tag_out.valid & ~reset;
    assign w_ret_vid   = w_ret_valid & (w_tag_out.tag == REQ_VID);
    assign w_ret_bot   = w_ret_valid & (w_tag_out.tag == REQ_BOT);
    assign w_ret_cpu   = w_ret_valid & (w_tag_out.tag == REQ_CPU);

    // r_mem_q is the BRAM word aligned with the pipe's last stage; holds keep data between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_q    <= '0;
            r_vid_hold <= '0;
            r_bot_hold <= '0;
            r_cpu_hold <= '0;
        end else begin
            r_mem_q <= mem_data;
            if (w_ret_vid) r_vid_hold <= r_mem_q;
            if (w_ret_bot) r_bot_hold <= r_mem_q;
            if (w_ret_cpu) r_cpu_hold <= r_mem_q;
        end
    end

    assign bot_gnt    = (w_winner == REQ_BOT);
    assign cpu_gnt    = (w_winner == REQ_CPU);
    assign mem_addr   = r_mem_addr;
    assign vid_data   = w_ret_vid ? r_mem_q : r_vid_hold;
    assign vid_stale  = w_ret_valid & w_tag_out.stolen;
    assign bot_rvalid = w_ret_bot;
    assign bot_rdata  = w_ret_bot ? r_mem_q : r_bot_hold;
    assign cpu_rvalid = w_ret_cpu;
    assign cpu_rdata  = w_ret_cpu ? r_mem_q : r_cpu_hold;

`ifdef WMARB_STATS_EN
    logic [WMARB_STAT_W-1:0] r_stat_bot;
    logic [WMARB_STAT_W-1:0] r_stat_cpu;
    logic [WMARB_STAT_W-1:0] r_stat_steal;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            r_stat_bot   <= '0;
            r_stat_cpu   <= '0;
            r_stat_steal <= '0;
        end else begin
            r_stat_bot   <= sat_inc(r_stat_bot, bot_gnt);
            r_stat_cpu   <= sat_inc(r_stat_cpu, cpu_gnt);
            r_stat_steal <= sat_inc(r_stat_steal, w_steal);
        end
    end

    assign stat_bot_cnt   = r_stat_bot;
    assign stat_cpu_cnt   = r_stat_cpu;
    assign stat_steal_cnt = r_stat_steal;
`endif

endmodule
